// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and data requesters, data first; `define ARB_FAIRNESS_EN bounds fetch starvation.
// Latency: req in N -> bus_req in N+1; bus_ack in M -> requester ack in M+1 (best case ack in N+2).
// Backpressure: one transaction in flight; requesters hold req until ack, bus stalls count toward TIMEOUT.
module mem_port_arbiter #(
  parameter int TIMEOUT         = 64,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifetch_req,
  input  logic [31:0] ifetch_addr,
  output logic [31:0] ifetch_rdata,
  output logic        ifetch_ack,
  output logic        ifetch_err,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_strb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ack,
  output logic        dmem_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_strb,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int TW = $clog2(TIMEOUT);

  if (TIMEOUT < 2 || MAX_DATA_STREAK < 1) begin : g_param_check
    $error("mem_port_arbiter: TIMEOUT must be >= 2 and MAX_DATA_STREAK >= 1");
  end

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
  logic          bus_req_nxt, bus_we_nxt;
  logic [31:0]   bus_addr_nxt, bus_wdata_nxt;
  logic [3:0]    bus_strb_nxt;
  logic          ifetch_ack_nxt, ifetch_err_nxt, dmem_ack_nxt, dmem_err_nxt;
  logic [31:0]   ifetch_rdata_nxt, dmem_rdata_nxt;
  logic [31:0]   resp_data;
  logic          fetch_starved;
  logic          grant_d;

`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  logic [SW-1:0] streak, streak_nxt;

  assign fetch_starved = (streak == SW'(MAX_DATA_STREAK));

  always_ff @(posedge clk) begin
    if (reset) streak <= '0;
    else       streak <= streak_nxt;
  end
`else
  assign fetch_starved = 1'b0;
`endif

  // Data belongs to the older instruction, so it wins unless fetch has been starved too long.
  assign grant_d = dmem_req && !(ifetch_req && fetch_starved);

  always_comb begin
    state_nxt        = state;
    tmo_cnt_nxt      = tmo_cnt;
    bus_req_nxt      = bus_req;
    bus_we_nxt       = bus_we;
    bus_addr_nxt     = bus_addr;
    bus_wdata_nxt    = bus_wdata;
    bus_strb_nxt     = bus_strb;
    ifetch_ack_nxt   = 1'b0;
    ifetch_err_nxt   = 1'b0;
    ifetch_rdata_nxt = ifetch_rdata;
    dmem_ack_nxt     = 1'b0;
    dmem_err_nxt     = 1'b0;
    dmem_rdata_nxt   = dmem_rdata;
    resp_data        = bus_ack ? bus_rdata : 32'h0;
`ifdef ARB_FAIRNESS_EN
    streak_nxt       = streak;
`endif
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt     = GRANT_D;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = dmem_we;
          bus_addr_nxt  = dmem_addr;
          bus_wdata_nxt = dmem_wdata;
          bus_strb_nxt  = dmem_strb;
`ifdef ARB_FAIRNESS_EN
          streak_nxt    = ifetch_req ? streak + 1'b1 : '0;
`endif
        end else if (ifetch_req) begin
          state_nxt     = GRANT_I;
          bus_req_nxt   = 1'b1;
          bus_we_nxt    = 1'b0;
          bus_addr_nxt  = ifetch_addr;
          bus_wdata_nxt = 32'h0;
          bus_strb_nxt  = 4'hF;
`ifdef ARB_FAIRNESS_EN
          streak_nxt    = '0;
`endif
        end
      end
      GRANT_I, GRANT_D: begin
        // A timeout completes like an ack but flags an error with zero data.
        if (bus_ack || tmo_cnt == TW'(TIMEOUT - 1)) begin
          state_nxt   = IDLE;
          tmo_cnt_nxt = '0;
          bus_req_nxt = 1'b0;
          if (state == GRANT_I) begin
            ifetch_ack_nxt   = 1'b1;
            ifetch_err_nxt   = !bus_ack;
            ifetch_rdata_nxt = resp_data;
          end else begin
            dmem_ack_nxt   = 1'b1;
            dmem_err_nxt   = !bus_ack;
            dmem_rdata_nxt = resp_data;
          end
        end else begin
          tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= 32'h0;
      bus_wdata    <= 32'h0;
      bus_strb     <= 4'h0;
      ifetch_ack   <= 1'b0;
      ifetch_err   <= 1'b0;
      ifetch_rdata <= 32'h0;
      dmem_ack     <= 1'b0;
      dmem_err     <= 1'b0;
      dmem_rdata   <= 32'h0;
    end else begin
      state        <= state_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      bus_req      <= bus_req_nxt;
      bus_we       <= bus_we_nxt;
      bus_addr     <= bus_addr_nxt;
      bus_wdata    <= bus_wdata_nxt;
      bus_strb     <= bus_strb_nxt;
      ifetch_ack   <= ifetch_ack_nxt;
      ifetch_err   <= ifetch_err_nxt;
      ifetch_rdata <= ifetch_rdata_nxt;
      dmem_ack     <= dmem_ack_nxt;
      dmem_err     <= dmem_err_nxt;
      dmem_rdata   <= dmem_rdata_nxt;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory bus between the instruction-fetch requester and the data-memory (load/store) requester.
- Serialises their transactions with a registered req/ack handshake.
- Registers read data back to the winning requester.
- Enforces a bus timeout that reports an error response.
- Sits between the fetch/memory pipeline stages and the bus interface; requester acks drive the hazard unit's stall inputs.

Parameters:
- TIMEOUT, 64: cycles bus_req may stay high without bus_ack before the arbiter aborts with error; must be >=2.
- MAX_DATA_STREAK, 4: consecutive data grants allowed while ifetch_req is pending (used only with ARB_FAIRNESS_EN).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- ifetch_req  input  1  fetch requests a read; held until ifetch_ack.
- ifetch_addr  input  32  fetch address; stable while ifetch_req is high.
- ifetch_rdata  output  32  read data; valid when ifetch_ack is high.
- ifetch_ack  output  1  one-cycle completion pulse.
- ifetch_err  output  1  high with ifetch_ack when the transaction timed out.
- dmem_req  input  1  data requester transaction request; held until dmem_ack.
- dmem_we  input  1  1 = write, 0 = read.
- dmem_addr  input  32  data address.
- dmem_wdata  input  32  write data.
- dmem_strb  input  4  byte enables for writes.
- dmem_rdata  output  32  read data; valid when dmem_ack is high.
- dmem_ack  output  1  one-cycle completion pulse.
- dmem_err  output  1  high with dmem_ack on timeout.
- bus_req  output  1  bus transaction request, registered.
- bus_we  output  1  registered write enable.
- bus_addr  output  32  registered address.
- bus_wdata  output  32  registered write data.
- bus_strb  output  4  registered byte enables; 4'hF for fetch reads.
- bus_rdata  input  32  bus read data; sampled when bus_ack is high.
- bus_ack  input  1  bus completion; may assert in the same cycle bus_req first goes high.

Behaviour:
- Reset (clk, reset: synchronous, active-high):
  - State is IDLE.
  - bus_req, bus_we, ifetch_ack, dmem_ack, ifetch_err and dmem_err are 0.
  - bus_addr, bus_wdata, ifetch_rdata and dmem_rdata are 32'h0; bus_strb is 4'h0.
  - Timeout counter and streak counter are 0.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - If dmem_req=1, go to GRANT_D: latch dmem_* into bus_*, set bus_req=1.
  - Otherwise, if ifetch_req=1, go to GRANT_I: bus_we=0, bus_strb=4'hF, bus_addr=ifetch_addr, set bus_req=1.
  - Data has fixed priority over fetch; the data access belongs to the older instruction.
- GRANT_x, no bus_ack:
  - Hold all bus_* outputs stable.
  - Increment the timeout counter.
- GRANT_x, bus_ack=1:
  - Next cycle: bus_req=0, x_ack=1 for exactly one cycle, x_rdata=bus_rdata (writes also copy bus_rdata), x_err=0.
  - Return to IDLE and clear the timeout counter.
- Timeout: if the counter reaches TIMEOUT-1 with no bus_ack, behave as ack but x_err=1 and x_rdata=32'h0; late bus_ack in IDLE is ignored.
- Latency:
  - Request in cycle N gives bus_req in N+1.
  - bus_ack in cycle M gives requester ack in M+1.
  - Best case is ack in N+2.
  - IDLE lasts at least one cycle between transactions (one bubble), so a new grant never overlaps an ack cycle.
- Requester deasserting req while granted: the transaction still completes and the ack pulse is still issued; the requester ignores it. No abort on the bus.
- Both requests in the same IDLE cycle: data wins. The fetch stays pending and is granted at the next IDLE cycle if still requested.
- Reset mid-transaction: bus_req drops the following cycle, no ack is issued, and the bus is assumed reset together with the core.
- ifetch_ack and dmem_ack are never high in the same cycle. bus_req is never high in IDLE.

Optional Feature:
- ARB_FAIRNESS_EN defined:
  - The streak counter counts consecutive GRANT_D entries made while ifetch_req=1.
  - When it equals MAX_DATA_STREAK and both requests are pending in IDLE, fetch is granted instead and the counter clears.
  - The counter also clears on any GRANT_I entry or when ifetch_req is low at a grant decision.
- ARB_FAIRNESS_EN undefined: strict data priority; the streak counter is absent.

Test Plan:
- Single fetch:
  - Stimulus: ifetch_req=1 with addr 32'h8000_0000; bus_ack=1 with rdata 32'h0000_0013 on the first bus_req cycle.
  - Required: bus_req high one cycle, ifetch_ack pulse 2 cycles after the request, ifetch_rdata=32'h0000_0013, ifetch_err=0.
- Simultaneous requests:
  - Stimulus: ifetch_req and dmem_req (write, addr 32'h8000_1000, wdata 32'hDEAD_BEEF, strb 4'h3) both high in cycle 0; bus acks after 2 cycles.
  - Required: the data write goes out first with the exact bus_* values; dmem_ack precedes ifetch_ack; fetch is granted after one IDLE bubble.
- Timeout:
  - Stimulus: dmem read, bus_ack never asserted, TIMEOUT=64.
  - Required: dmem_ack=1, dmem_err=1, dmem_rdata=0 exactly 64 cycles after bus_req rose; a late bus_ack changes nothing.
- Reset mid-transaction:
  - Stimulus: reset in the second cycle of GRANT_I.
  - Required: bus_req=0 next cycle, no ifetch_ack, and a fresh request afterwards behaves as in the single-fetch test.
- Request drop:
  - Stimulus: ifetch_req falls one cycle after the grant.
  - Required: bus transaction unchanged, ifetch_ack still pulses once.
- Fairness (ARB_FAIRNESS_EN, MAX_DATA_STREAK=4):
  - Stimulus: continuous dmem_req and ifetch_req.
  - Required: grant pattern D,D,D,D,I repeating. Without the macro, fetch is never granted.
